// File: rtl/handshake_arbiter.sv
// Round-robin arbiter that shares one downstream valid/ready channel between
// NREQ requesters, holding each grant for a burst and rotating priority on release.
module handshake_arbiter #(
  parameter int NREQ          = 4,
  parameter int WIDTH         = 32,
  parameter int MAX_BURST     = 4,
  parameter int STALL_TIMEOUT = 8,
  localparam int SRCW         = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_port1,
  output logic                  out_last,
  output logic [SRCW-1:0]       out_src,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SRCW-1:0] grant;
  logic [SRCW-1:0] rr_ptr;
  logic [SRCW-1:0] winner;
  logic [7:0]      beat_cnt;
  logic [7:0]      stall_cnt;
  logic [7:0]      beat_inc;
  logic [7:0]      stall_inc;
  logic            any_req;
  logic            found;
  logic            g_valid;
  logic            g_last;
  logic            xfer;
  logic            release_now;
  int              idx;

  // Search starts just after the last granted index so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        winner = SRCW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req   = |req_valid;
  assign g_valid   = req_valid[grant];
  assign g_last    = req_last[grant];
  assign xfer      = (state == GRANT) && g_valid && out_ready;
  assign beat_inc  = beat_cnt + 8'd1;
  assign stall_inc = stall_cnt + 8'd1;

  // Backpressure (valid high, ready low) neither advances nor clears the stall count.
  assign release_now = (state == GRANT) &&
                       ((xfer && (g_last || (beat_inc == 8'(MAX_BURST)))) ||
                        (!g_valid && (stall_inc == 8'(STALL_TIMEOUT))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      rr_ptr    <= SRCW'(NREQ - 1);
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= winner;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            beat_cnt  <= beat_inc;
            stall_cnt <= '0;
          end else if (!g_valid) begin
            stall_cnt <= stall_inc;
          end
          if (release_now) begin
            rr_ptr <= grant;
          end
        end
        default: ;
      endcase
    end
  end

  // In GRANT the granted requester is wired straight through to the shared channel.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_port1 = '0;
    out_last  = 1'b0;
    out_src   = grant;
    busy      = (state == GRANT);
    if (state == GRANT) begin
      out_valid        = g_valid;
      out_port1        = req_data[grant*WIDTH +: WIDTH];
      out_last         = g_last;
      req_ready[grant] = out_ready;
    end
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Randomized and directed bench for handshake_arbiter, checked every cycle
// against a cycle-level behavioural model of the arbitration rules.
module tb_handshake_arbiter;

  localparam int NREQ          = 4;
  localparam int WIDTH         = 32;
  localparam int MAX_BURST     = 4;
  localparam int STALL_TIMEOUT = 8;
  localparam int SRCW          = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_port1;
  logic                  out_last;
  logic [SRCW-1:0]       out_src;
  logic                  out_ready;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  bit               modelValid = 1'b0;
  bit               mBusy;
  int               mGrant;
  int               mPtr;
  int               mBeats;
  int               mStalls;
  int               mSrc;
  int               acceptedCount[NREQ];
  logic [WIDTH-1:0] dataWord[NREQ];
  int               srcLog[$];

  handshake_arbiter #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .MAX_BURST(MAX_BURST),
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_port1(out_port1),
    .out_last(out_last),
    .out_src(out_src),
    .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int pickWinner(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mBusy   = 1'b0;
    mGrant  = 0;
    mSrc    = 0;
    mPtr    = NREQ - 1;
    mBeats  = 0;
    mStalls = 0;
  endtask

  // Advance the reference model by one clock using the inputs of this cycle.
  task automatic modelStep(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic ordy, input logic r);
    int w;
    bit done;
    if (r) begin
      modelReset();
    end else if (!mBusy) begin
      w = pickWinner(v);
      if (w >= 0) begin
        mBusy   = 1'b1;
        mGrant  = w;
        mSrc    = w;
        mBeats  = 0;
        mStalls = 0;
      end
    end else begin
      done = 1'b0;
      if (v[mGrant] && ordy) begin
        acceptedCount[mGrant]++;
        mBeats++;
        mStalls = 0;
        if (l[mGrant] || mBeats == MAX_BURST) done = 1'b1;
      end else if (!v[mGrant]) begin
        mStalls++;
        if (mStalls == STALL_TIMEOUT) done = 1'b1;
      end
      if (done) begin
        mBusy = 1'b0;
        mPtr  = mGrant;
      end
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic ordy, input logic r);
    logic [NREQ-1:0] expReady;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_last  = l;
    out_ready = ordy;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dataWord[i];
    #1;
    if (modelValid) begin
      expReady = '0;
      if (mBusy) expReady[mGrant] = ordy;
      checkOutput("busy", busy, mBusy);
      checkOutput("out_valid", out_valid, mBusy ? v[mGrant] : 1'b0);
      checkOutput("out_port1", out_port1, mBusy ? dataWord[mGrant] : '0);
      checkOutput("out_last", out_last, mBusy ? l[mGrant] : 1'b0);
      checkOutput("out_src", out_src, mSrc);
      checkOutput("req_ready", req_ready, expReady);
    end
    modelStep(v, l, ordy, r);
    if (r) modelValid = 1'b1;
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < NREQ; i++) acceptedCount[i] = 0;
  endtask

  initial begin
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] l;
    int expOrder[5];
    int expSeq[7];

    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) dataWord[i] = 32'h1000_0000 + 32'(i);
    modelReset();

    // Single request from requester 2.
    doReset();
    applyStimulus('0, '0, 1'b1, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_src", out_src, 0);
    dataWord[2] = 32'hA5A5_0002;
    applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0);
    checkOutput("tp1_busy", busy, 1'b1);
    checkOutput("tp1_src", out_src, 2);
    checkOutput("tp1_data", out_port1, 32'hA5A5_0002);
    checkOutput("tp1_ready", req_ready, 4'b0100);
    applyStimulus('0, '0, 1'b1, 1'b0);
    checkOutput("tp1_idle", busy, 1'b0);

    // All requesters single-beat: strict rotation with an idle cycle between grants.
    doReset();
    srcLog.delete();
    for (int c = 0; c < 10; c++) begin
      applyStimulus('1, '1, 1'b1, 1'b0);
      if (busy) srcLog.push_back(int'(out_src));
    end
    expOrder = '{0, 1, 2, 3, 0};
    checkOutput("tp2_grants", srcLog.size(), 5);
    for (int i = 0; i < 5 && i < srcLog.size(); i++) checkOutput("tp2_order", srcLog[i], expOrder[i]);

    // Six-beat packet cut by burst limit, requester 3 interleaves one grant.
    doReset();
    srcLog.delete();
    for (int c = 0; c < 30; c++) begin
      v = '0;
      l = '0;
      v[1] = (acceptedCount[1] < 6);
      l[1] = (acceptedCount[1] == 5);
      v[3] = (acceptedCount[3] < 1);
      l[3] = 1'b1;
      applyStimulus(v, l, 1'b1, 1'b0);
      if (busy && out_valid && out_ready) srcLog.push_back(int'(out_src));
    end
    expSeq = '{1, 1, 1, 1, 3, 1, 1};
    checkOutput("tp3_beats", srcLog.size(), 7);
    for (int i = 0; i < 7 && i < srcLog.size(); i++) checkOutput("tp3_seq", srcLog[i], expSeq[i]);

    // Long downstream backpressure never releases the grant.
    doReset();
    for (int c = 0; c < 21; c++) applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
    checkOutput("tp4_held", busy, 1'b1);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
    checkOutput("tp4_ready", req_ready, 4'b0001);

    // Stall timeout while requester 1 waits.
    doReset();
    applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 12; c++) applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);

    // Reset during a multi-beat burst, then requester 0 wins again.
    doReset();
    for (int c = 0; c < 3; c++) applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
    checkOutput("tp6_idle", busy, 1'b0);
    applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
    checkOutput("tp6_src", out_src, 0);

    // Randomized traffic with persistent per-requester valids.
    v = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(3) == 0) v[i] = ~v[i];
        l[i] = ($urandom_range(3) == 0);
        dataWord[i] = $urandom;
      end
      applyStimulus(v, l, ($urandom_range(3) != 0), ($urandom_range(199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
